uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
- REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, meaning CLK cycles per serial bit (legal range 4..65535).
- REQ-002 SHALL have port CLK  input  1  single clock for all logic.
- REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
- REQ-004 SHALL have port RXD  input  1  asynchronous serial line (8N1 idle-high; it connects to an upstream TXD).
- REQ-005 SHALL have port out_data  output  8  received byte.
- REQ-006 SHALL have port out_valid  output  1  out_data holds an unconsumed byte.
- REQ-007 SHALL have port out_ready  input  1  consumer accepts the byte when out_valid && out_ready.
- REQ-008 SHALL have port frame_err  output  1  one-cycle pulse when a bad stop bit is detected.
- REQ-009 SHALL have port overrun  output  1  sticky flag for a dropped byte.
- REQ-010 SHALL have port ovr_clr  input  1  synchronous clear of overrun.

Function
- REQ-011 SHALL pass RXD through a two-flop synchronizer (reset value 1); all logic uses the synchronized value rxs.
- REQ-012 SHALL implement states IDLE, START, DATA, STOP, WAIT_HI, plus PARITY when UART_RX_PARITY_EN is defined.
- REQ-013 SHALL go from IDLE to START on the first cycle rxs==0, and load the bit counter for CLKS_PER_BIT/2 (integer division).
- REQ-014 SHALL sample rxs in START when the counter expires (mid-bit): 1 -> IDLE (false start, no outputs change); 0 -> DATA, with the counter reloaded to CLKS_PER_BIT.
- REQ-015 SHALL sample 8 data bits in DATA, each one CLKS_PER_BIT after the previous sample, LSB first, into a shift register; after bit 7 it goes to STOP (or PARITY).
- REQ-016 SHALL act on the mid-stop sample in STOP: 1 -> deliver the byte and go to IDLE; 0 -> pulse frame_err for one cycle, drop the byte and go to WAIT_HI.
- REQ-017 SHALL hold WAIT_HI until rxs==1, then go to IDLE (break handling).
- REQ-018 SHALL on delivery load out_data and set out_valid on the clock edge following the mid-stop sample cycle; total latency from the RXD stop-bit midpoint is at most 3 cycles.
- REQ-019 SHALL hold out_data stable while out_valid==1 and clear out_valid on the edge where out_ready==1.
- REQ-020 SHALL on delivery while out_valid==1 and out_ready==0: set overrun, keep the old out_data and drop the new byte.
- REQ-021 SHALL on delivery in the same cycle as out_valid && out_ready: load the new byte, keep out_valid at 1 and leave overrun unchanged.
- REQ-022 SHALL clear overrun on ovr_clr==1; if ovr_clr and a new overrun coincide, overrun SHALL end up set.
- REQ-023 SHALL use a counter width of $clog2(CLKS_PER_BIT+1) bits and no wrap-around; the counter reloads on every expiry.

Reset
- REQ-024 SHALL force the following while reset==0, independent of CLK: state=IDLE, synchronizer=1, out_data=0x00, out_valid=0, frame_err=0, overrun=0, counters=0.
- REQ-025 SHALL on reset assertion mid-frame discard the partial byte; after release, reception restarts at the next falling edge of rxs.

Configuration
- REQ-026 SHALL use macro UART_RX_PARITY_EN; when defined, an even-parity bit is sampled after bit 7 in state PARITY.
- REQ-027 SHALL with UART_RX_PARITY_EN defined and a parity mismatch: drop the byte and pulse frame_err, while the stop bit is still checked. Port parity_err (output, 1) SHALL pulse for one cycle.
- REQ-028 SHALL with UART_RX_PARITY_EN undefined have no PARITY state and no parity_err port; frames are 8N1.

Structure
- REQ-029 SHALL place the state encoding (3-bit localparams), DATA_BITS=8 and the RXD idle level in the shared package uart_pkg, which the matching TX block also uses.
- REQ-030 SHALL implement the synchronizer as sub-module sync2 (1-bit, reset value parameter), instantiated once.

Verification (CLKS_PER_BIT=16, bit = 16 cycles)
- REQ-031 SHALL check: frame 0xA5 with out_ready=1 -> out_data=0xA5, out_valid high one cycle, frame_err=0, overrun=0.
- REQ-032 SHALL check: RXD low for 4 cycles, then high -> no out_valid, FSM back in IDLE, no frame_err.
- REQ-033 SHALL check: frame 0x3C with stop bit 0, then RXD held low 40 cycles -> one frame_err pulse, no out_valid; next frame 0x11 received correctly.
- REQ-034 SHALL check: frames 0x01 then 0x02 with out_ready=0 -> out_data=0x01, overrun=1; ovr_clr pulse -> overrun=0.
- REQ-035 SHALL check: reset pulsed low during bit 4 of 0xFF -> all outputs at reset values; following 0x5A received as 0x5A.
- REQ-036 SHALL check, with UART_RX_PARITY_EN: 0x07 sent with parity bit 0 -> parity_err and frame_err pulse, no out_valid.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and state encoding (RX and TX).
// UART_RX_PARITY_EN adds the PARITY state.
package uart_pkg;

  localparam int   DATA_BITS = 8;
  localparam logic RXD_IDLE  = 1'b1;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_START   = 3'd1;
  localparam logic [2:0] ST_DATA    = 3'd2;
  localparam logic [2:0] ST_STOP    = 3'd3;
  localparam logic [2:0] ST_WAIT_HI = 3'd4;
  localparam logic [2:0] ST_PARITY  = 3'd5;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    START   = ST_START,
    DATA    = ST_DATA,
    STOP    = ST_STOP,
`ifdef UART_RX_PARITY_EN
    PARITY  = ST_PARITY,
`endif
    WAIT_HI = ST_WAIT_HI
  } rx_state_t;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer for a single asynchronous bit.
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with valid/ready output and overrun flag.
// UART_RX_PARITY_EN adds an even-parity bit and the parity_err port.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       RXD,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       overrun,
  input  logic       ovr_clr
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  rx_state_t            state, state_nxt;
  logic                 rxs;
  logic [CW-1:0]        cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 expire;
  logic                 load_half, load_full, shift_en, deliver, ferr_set;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad, par_capture, perr_set;
`endif

  sync2 #(.RESET_VAL(RXD_IDLE)) u_sync (
    .clk   (CLK),
    .rst_n (reset),
    .d     (RXD),
    .q     (rxs)
  );

  // Expiry is the cycle the counter reads 1, so each bit is sampled exactly
  // CLKS_PER_BIT cycles after the previous one.
  assign expire = (cnt == CNT_ONE);

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_half = 1'b0;
    load_full = 1'b0;
    shift_en  = 1'b0;
    deliver   = 1'b0;
    ferr_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_capture = 1'b0;
    perr_set    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (rxs != RXD_IDLE) begin
          state_nxt = START;
          load_half = 1'b1;
        end
      end
      START: begin
        if (expire) begin
          load_full = 1'b1;
          state_nxt = (rxs == RXD_IDLE) ? IDLE : DATA;
        end
      end
      DATA: begin
        if (expire) begin
          shift_en  = 1'b1;
          load_full = 1'b1;
          if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (expire) begin
          par_capture = 1'b1;
          load_full   = 1'b1;
          state_nxt   = STOP;
        end
      end
`endif
      STOP: begin
        if (expire) begin
          load_full = 1'b1;
          if (rxs == RXD_IDLE) begin
            state_nxt = IDLE;
`ifdef UART_RX_PARITY_EN
            deliver   = !par_bad;
            ferr_set  = par_bad;
`else
            deliver   = 1'b1;
`endif
          end else begin
            state_nxt = WAIT_HI;
            ferr_set  = 1'b1;
          end
`ifdef UART_RX_PARITY_EN
          perr_set = par_bad;
`endif
        end
      end
      WAIT_HI: begin
        if (rxs == RXD_IDLE) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      if (load_half)      cnt <= CNT_HALF;
      else if (load_full) cnt <= CNT_FULL;
      else if (cnt != '0) cnt <= cnt - CNT_ONE;

      if (load_half)     bit_idx <= '0;
      else if (shift_en) bit_idx <= bit_idx + 3'd1;

      if (shift_en) shreg <= {rxs, shreg[DATA_BITS-1:1]};

      frame_err <= ferr_set;
`ifdef UART_RX_PARITY_EN
      if (par_capture) par_bad <= ^{shreg, rxs};
      parity_err <= perr_set;
`endif

      // A new overrun wins over a simultaneous clear.
      if (deliver && out_valid && !out_ready) overrun <= 1'b1;
      else if (ovr_clr)                       overrun <= 1'b0;

      if (deliver && (!out_valid || out_ready)) begin
        out_data  <= shreg;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx (CLKS_PER_BIT=16).
module tb_uart_rx;
  import uart_pkg::*;

  localparam int BIT = 16;

  logic       CLK = 1'b0;
  logic       reset = 1'b0;
  logic       RXD = 1'b1;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       frame_err;
  logic       overrun;
  logic       ovr_clr = 1'b0;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  int         pecnt = 0;
`endif

  int checks = 0;
  int failures = 0;
  int vcnt = 0;
  int fecnt = 0;
  logic [7:0] last_data = 8'h00;
  int v0, f0;

  uart_rx #(.CLKS_PER_BIT(BIT)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .RXD       (RXD),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .overrun   (overrun),
    .ovr_clr   (ovr_clr)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (out_valid) begin
      vcnt <= vcnt + 1;
      last_data <= out_data;
    end
    if (frame_err) fecnt <= fecnt + 1;
`ifdef UART_RX_PARITY_EN
    if (parity_err) pecnt <= pecnt + 1;
`endif
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    RXD = v;
    cycles(BIT);
  endtask

  task automatic send_bits(input logic [7:0] d);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^d);
`endif
  endtask

  task automatic send(input logic [7:0] d);
    send_bits(d);
    drive_bit(1'b1);
    cycles(4);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cycles(3);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'h00);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    reset = 1'b1;
    cycles(5);

    // Clean frame with consumer ready
    v0 = vcnt; f0 = fecnt;
    send(8'hA5);
    chk("a5_data", 32'(last_data), 32'hA5);
    chk("a5_vcycles", 32'(vcnt - v0), 32'd1);
    chk("a5_ferr", 32'(fecnt - f0), 32'd0);
    chk("a5_ovr", 32'(overrun), 32'd0);

    v0 = vcnt;
    send(8'h00);
    chk("00_data", 32'(last_data), 32'h00);
    chk("00_vcycles", 32'(vcnt - v0), 32'd1);

    // False start: glitch shorter than half a bit
    v0 = vcnt; f0 = fecnt;
    RXD = 1'b0;
    cycles(4);
    RXD = 1'b1;
    cycles(30);
    chk("fs_valid", 32'(vcnt - v0), 32'd0);
    chk("fs_ferr", 32'(fecnt - f0), 32'd0);
    chk("fs_state", 32'(dut.state), 32'(ST_IDLE));

    // Bad stop bit followed by a held-low break
    v0 = vcnt; f0 = fecnt;
    send_bits(8'h3C);
    RXD = 1'b0;
    cycles(BIT + 40);
    RXD = 1'b1;
    cycles(10);
    chk("brk_ferr", 32'(fecnt - f0), 32'd1);
    chk("brk_valid", 32'(vcnt - v0), 32'd0);
    chk("brk_state", 32'(dut.state), 32'(ST_IDLE));
    v0 = vcnt;
    send(8'h11);
    chk("after_brk_data", 32'(last_data), 32'h11);
    chk("after_brk_vcycles", 32'(vcnt - v0), 32'd1);

    // Overrun with consumer stalled
    out_ready = 1'b0;
    send(8'h01);
    chk("ovr_first_valid", 32'(out_valid), 32'd1);
    chk("ovr_first_flag", 32'(overrun), 32'd0);
    send(8'h02);
    chk("ovr_data", 32'(out_data), 32'h01);
    chk("ovr_valid", 32'(out_valid), 32'd1);
    chk("ovr_flag", 32'(overrun), 32'd1);
    ovr_clr = 1'b1;
    cycles(1);
    ovr_clr = 1'b0;
    chk("ovr_clr", 32'(overrun), 32'd0);
    chk("ovr_hold_data", 32'(out_data), 32'h01);
    out_ready = 1'b1;
    cycles(2);
    chk("ovr_drain", 32'(out_valid), 32'd0);

    // Asynchronous reset in the middle of bit 4 of 0xFF
    RXD = 1'b0;
    cycles(BIT);
    RXD = 1'b1;
    cycles(4 * BIT + BIT / 2);
    reset = 1'b0;
    #1;
    chk("mid_rst_data", 32'(out_data), 32'h00);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ferr", 32'(frame_err), 32'd0);
    chk("mid_rst_ovr", 32'(overrun), 32'd0);
    chk("mid_rst_state", 32'(dut.state), 32'(ST_IDLE));
    cycles(3);
    reset = 1'b1;
    cycles(5 * BIT);
    v0 = vcnt; f0 = fecnt;
    send(8'h5A);
    chk("post_rst_data", 32'(last_data), 32'h5A);
    chk("post_rst_vcycles", 32'(vcnt - v0), 32'd1);
    chk("post_rst_ferr", 32'(fecnt - f0), 32'd0);

`ifdef UART_RX_PARITY_EN
    begin
      int p0;
      v0 = vcnt; f0 = fecnt; p0 = pecnt;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(i < 3);
      drive_bit(1'b0);
      drive_bit(1'b1);
      cycles(4);
      chk("par_perr", 32'(pecnt - p0), 32'd1);
      chk("par_ferr", 32'(fecnt - f0), 32'd1);
      chk("par_valid", 32'(vcnt - v0), 32'd0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
